// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot BCD alarm store with per-slot ring/snooze control.
//
// Each slot holds an hh:mm alarm time (four BCD digits, compared raw) and an
// enable bit. A slot starts ringing on the rising edge of its match against
// the running time. It stays ringing until stop_alarm, a load, or reset.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   defined     - snooze moves ringing slots to SNOOZE for SNOOZE_MIN
//                 one_minute ticks, after which they ring again.
//   not defined - snooze input, SNOOZE state and snooze counters are absent.
//
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   load_new_alarm         write slot load_idx (out-of-range index ignored)
//   load_idx               slot to write
//   new_alarm_*            BCD time to write
//   new_alarm_en           enable written with the time
//   current_time_*         running BCD time
//   one_minute             one-cycle pulse per minute
//   stop_alarm             silences every ringing/snoozing slot
//   snooze                 snoozes every ringing slot
//   rd_idx                 readback slot select (out of range reads zero)
//   alarm_time_*           stored time of slot rd_idx
//   alarm_en_out           stored enable of slot rd_idx
//   alarm_active           per-slot ringing flag
//   sound_alarm            OR of alarm_active

// One alarm slot: storage, match edge detect and ring/snooze FSM.
module alarm_slot #(
    parameter int SNOOZE_MIN = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_time,
    input  logic        load_en,
    input  logic [15:0] cur_time,
    input  logic        one_minute,
    input  logic        stop_alarm,
    input  logic        snooze,
    output logic [15:0] alarm_time,
    output logic        alarm_en,
    output logic        ringing
);
`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
`else
    typedef enum logic [0:0] {IDLE, RINGING} state_t;
`endif

    state_t state, state_nxt;
    logic   match, match_q;

    assign match   = alarm_en && (alarm_time == cur_time);
    assign ringing = (state == RINGING);

    // A load forces match_q high so an alarm written equal to the current
    // time does not fire until the time leaves and comes back.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alarm_time <= '0;
            alarm_en   <= 1'b0;
            match_q    <= 1'b0;
            state      <= IDLE;
        end else begin
            state <= state_nxt;
            if (load) begin
                alarm_time <= load_time;
                alarm_en   <= load_en;
                match_q    <= 1'b1;
            end else begin
                match_q <= match;
            end
        end
    end

`ifdef ALARM_SNOOZE_EN
    logic [3:0] cnt, cnt_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (load || stop_alarm) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE:    if (match && !match_q) state_nxt = RINGING;
                RINGING: if (snooze) begin
                    state_nxt = SNOOZE;
                    cnt_nxt   = 4'(SNOOZE_MIN);
                end
                SNOOZE:  if (one_minute) begin
                    // Tick that takes the counter from 1 ends the snooze.
                    if (cnt == 4'd1) begin
                        state_nxt = RINGING;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
`else
    logic unused_snooze;
    assign unused_snooze = snooze ^ one_minute ^ (SNOOZE_MIN == 0);

    always_comb begin
        state_nxt = state;
        if (load || stop_alarm) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (match && !match_q) state_nxt = RINGING;
                default: state_nxt = state;
            endcase
        end
    end
`endif
endmodule

module alarm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 10,
    parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_new_alarm,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [3:0]            new_alarm_ms_hr,
    input  logic [3:0]            new_alarm_ls_hr,
    input  logic [3:0]            new_alarm_ms_min,
    input  logic [3:0]            new_alarm_ls_min,
    input  logic                  new_alarm_en,
    input  logic [3:0]            current_time_ms_hr,
    input  logic [3:0]            current_time_ls_hr,
    input  logic [3:0]            current_time_ms_min,
    input  logic [3:0]            current_time_ls_min,
    input  logic                  one_minute,
    input  logic                  stop_alarm,
    input  logic                  snooze,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [3:0]            alarm_time_ms_hr,
    output logic [3:0]            alarm_time_ls_hr,
    output logic [3:0]            alarm_time_ms_min,
    output logic [3:0]            alarm_time_ls_min,
    output logic                  alarm_en_out,
    output logic [NUM_ALARMS-1:0] alarm_active,
    output logic                  sound_alarm
);
    logic [NUM_ALARMS-1:0][15:0] slot_time;
    logic [NUM_ALARMS-1:0]       slot_en;
    logic [NUM_ALARMS-1:0]       slot_load;
    logic [15:0]                 cur_time, new_time, rd_time;
    logic                        rd_en;

    assign cur_time = {current_time_ms_hr, current_time_ls_hr,
                       current_time_ms_min, current_time_ls_min};
    assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr,
                       new_alarm_ms_min, new_alarm_ls_min};

    generate
        for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
            // An out-of-range load_idx decodes to no slot, so it is ignored.
            assign slot_load[i] = load_new_alarm && (load_idx == IDX_W'(i));

            alarm_slot #(.SNOOZE_MIN(SNOOZE_MIN)) u_slot (
                .clock      (clock),
                .reset      (reset),
                .load       (slot_load[i]),
                .load_time  (new_time),
                .load_en    (new_alarm_en),
                .cur_time   (cur_time),
                .one_minute (one_minute),
                .stop_alarm (stop_alarm),
                .snooze     (snooze),
                .alarm_time (slot_time[i]),
                .alarm_en   (slot_en[i]),
                .ringing    (alarm_active[i])
            );
        end
    endgenerate

    // Decoded mux: an out-of-range rd_idx selects nothing and reads zero.
    always_comb begin
        rd_time = '0;
        rd_en   = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_time = slot_time[i];
                rd_en   = slot_en[i];
            end
        end
    end

    assign {alarm_time_ms_hr, alarm_time_ls_hr,
            alarm_time_ms_min, alarm_time_ls_min} = rd_time;
    assign alarm_en_out = rd_en;
    assign sound_alarm  = |alarm_active;
endmodule

// File: tb/tb_alarm_bank.sv
module tb_alarm_bank;
    localparam int NA = 6;
    localparam int SM = 10;
    localparam int IW = 3;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic load_new_alarm = 1'b0, new_en = 1'b0;
    logic one_minute = 1'b0, stop_alarm = 1'b0, snooze = 1'b0;
    logic [IW-1:0] load_idx = '0, rd_idx = '0;
    logic [15:0] nt = '0, cur = '0;
    logic [3:0] a_mh, a_lh, a_mm, a_lm;
    logic a_en;
    logic [NA-1:0] active;
    logic sound;

    always #5 clock = ~clock;

    alarm_bank #(.NUM_ALARMS(NA), .SNOOZE_MIN(SM)) dut (
        .clock(clock), .reset(reset),
        .load_new_alarm(load_new_alarm), .load_idx(load_idx),
        .new_alarm_ms_hr(nt[15:12]), .new_alarm_ls_hr(nt[11:8]),
        .new_alarm_ms_min(nt[7:4]), .new_alarm_ls_min(nt[3:0]),
        .new_alarm_en(new_en),
        .current_time_ms_hr(cur[15:12]), .current_time_ls_hr(cur[11:8]),
        .current_time_ms_min(cur[7:4]), .current_time_ls_min(cur[3:0]),
        .one_minute(one_minute), .stop_alarm(stop_alarm), .snooze(snooze),
        .rd_idx(rd_idx),
        .alarm_time_ms_hr(a_mh), .alarm_time_ls_hr(a_lh),
        .alarm_time_ms_min(a_mm), .alarm_time_ls_min(a_lm),
        .alarm_en_out(a_en), .alarm_active(active), .sound_alarm(sound)
    );

    typedef struct packed {
        logic [NA-1:0] act;
        logic [15:0]   rtime;
        logic          ren;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: what each slot holds and whether it rings, or how
    // many minutes of snooze remain (0 = not snoozing).
    logic [15:0] m_time[NA];
    bit          m_en[NA];
    bit          m_ring[NA];
    int          m_left[NA];
    bit          m_prev[NA];

    function automatic void model_reset();
        for (int i = 0; i < NA; i++) begin
            m_time[i] = '0; m_en[i] = 0; m_ring[i] = 0; m_left[i] = 0; m_prev[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        bit match;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NA; i++) begin
            match = m_en[i] && (m_time[i] == cur);
            if (load_new_alarm && int'(load_idx) == i) begin
                m_time[i] = nt; m_en[i] = new_en;
                m_ring[i] = 0; m_left[i] = 0; m_prev[i] = 1;
            end else begin
                if (stop_alarm) begin
                    m_ring[i] = 0; m_left[i] = 0;
                end else if (SNZ && snooze && m_ring[i]) begin
                    m_ring[i] = 0; m_left[i] = SM;
                end else if (m_left[i] > 0) begin
                    if (one_minute) begin
                        if (m_left[i] == 1) m_ring[i] = 1;
                        m_left[i] = m_left[i] - 1;
                    end
                end else if (!m_ring[i] && match && !m_prev[i]) begin
                    m_ring[i] = 1;
                end
                m_prev[i] = match;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        for (int i = 0; i < NA; i++) e.act[i] = m_ring[i];
        if (int'(rd_idx) < NA) begin
            e.rtime = m_time[rd_idx];
            e.ren   = m_en[rd_idx];
        end
        return e;
    endfunction

    // One clock: the model takes the edge with the inputs in place, then
    // pulses drop, a new readback slot is chosen and the expectation queued.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        load_new_alarm = 0; one_minute = 0; stop_alarm = 0; snooze = 0;
        rd_idx = IW'($urandom_range(0, 7));
        q.push_back(model_out());
    endtask

    task automatic do_load(input int idx, input logic [15:0] t, input logic en);
        load_new_alarm = 1; load_idx = IW'(idx); nt = t; new_en = en;
        tick();
    endtask

    // Monitor: every output cycle is compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (active !== e.act) begin
                    errors++; $display("FAIL alarm_active got %b exp %b t=%0t", active, e.act, $time);
                end
                checks++;
                if (sound !== (|e.act)) begin
                    errors++; $display("FAIL sound_alarm got %b exp %b t=%0t", sound, |e.act, $time);
                end
                checks++;
                if ({a_mh, a_lh, a_mm, a_lm} !== e.rtime) begin
                    errors++; $display("FAIL readback_time idx=%0d got %h exp %h t=%0t",
                                       rd_idx, {a_mh, a_lh, a_mm, a_lm}, e.rtime, $time);
                end
                checks++;
                if (a_en !== e.ren) begin
                    errors++; $display("FAIL readback_en idx=%0d got %b exp %b t=%0t", rd_idx, a_en, e.ren, $time);
                end
            end
        end
    end

    logic [15:0] tlist[4] = '{16'h0729, 16'h0730, 16'h1200, 16'h2359};

    initial begin
        model_reset();
        repeat (2) tick();
        reset = 0;
        repeat (10) tick();

        // Slot 2 fires on the 07:29 -> 07:30 edge.
        cur = 16'h0729;
        do_load(2, 16'h0730, 1'b1);
        tick();
        cur = 16'h0730;
        repeat (4) tick();
        // Stop while time still matches: no re-fire until time leaves/returns.
        stop_alarm = 1; tick();
        repeat (3) tick();
        cur = 16'h0731; tick();
        cur = 16'h0730; repeat (2) tick();
        // Snooze then ten minute ticks.
        snooze = 1; tick();
        for (int k = 0; k < SM; k++) begin
            one_minute = 1; tick(); tick();
        end
        tick();
        stop_alarm = 1; tick();

        // Alarm loaded equal to current time does not fire.
        cur = 16'h1200; tick();
        do_load(0, 16'h1200, 1'b1);
        repeat (3) tick();

        // Stop and snooze together on a ringing slot.
        cur = 16'h0730; repeat (2) tick();
        stop_alarm = 1; snooze = 1; tick();
        repeat (2) tick();

        // Out-of-range load is ignored.
        do_load(7, 16'h2359, 1'b1);
        cur = 16'h2359; repeat (3) tick();

        // Clearing enable via load while ringing.
        cur = 16'h1200; tick(); cur = 16'h0730; tick(); tick();
        do_load(2, 16'h0730, 1'b0);
        repeat (2) tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) begin
                load_new_alarm = 1; load_idx = IW'($urandom_range(0, 7));
                nt = tlist[$urandom_range(0, 3)]; new_en = 1'($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 3) == 0) cur = tlist[$urandom_range(0, 3)];
            one_minute = ($urandom_range(0, 2) == 0);
            stop_alarm = ($urandom_range(0, 24) == 0);
            snooze     = ($urandom_range(0, 5) == 0);
            tick();
        end

        // One slot ringing, another snoozing, then asynchronous reset.
        stop_alarm = 1; tick();
        cur = 16'h0759;
        do_load(1, 16'h0800, 1'b1);
        do_load(3, 16'h0801, 1'b1);
        cur = 16'h0800; repeat (2) tick();
        snooze = 1; tick();
        cur = 16'h0801; repeat (2) tick();
        #2;
        reset = 1;
        #1;
        checks++;
        if (active !== '0 || sound !== 1'b0) begin
            errors++; $display("FAIL async_reset active=%b sound=%b exp 0", active, sound);
        end
        model_reset();
        void'(q.pop_back());
        q.push_back(model_out());
        repeat (3) tick();
        reset = 0;
        repeat (10) tick();

        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL queue_drain left=%0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
